// File: rtl/wnd_pkg.sv
// Shared definitions for the sliding-window generator.
// Holds the ceil-log2 helper, default geometry and its derived sizes,
// the coordinate widths and the coordinate payload struct.
package wnd_pkg;

  // ceil(log2(v)), never below 1 so it is usable as an address width
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_PIX_W      = 8;
  localparam int unsigned DEF_COLS       = 7;
  localparam int unsigned DEF_ROWS       = 7;
  localparam int unsigned DEF_PPC        = 4;
  localparam int unsigned DEF_MAX_LINE_W = 2048;

  localparam int unsigned BEATS = DEF_MAX_LINE_W / DEF_PPC;
  localparam int unsigned AW    = clog2(BEATS);
  localparam int unsigned WBW   = DEF_COLS - 1 + DEF_PPC;

  localparam int unsigned ROW_W = 10;
  localparam int unsigned COL_W = 12;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } wnd_coord_t;

endpackage

// File: rtl/wnd_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Ports: i_clk clock; i_we/i_waddr/i_wdata write; i_re/i_raddr read request;
//        o_rdata read data one cycle after i_re. Contents are never reset.
module wnd_line_ram
  import wnd_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // write and registered read
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/wnd_multi.sv
// Multi-pixel sliding-window generator.
// Buffers ROWS-1 lines and emits PPC adjacent ROWS x COLS windows per beat.
// Ports: c clock; rst_n async active-low reset; p/pv/lv/fv raster input
//        (lane 0 leftmost); w windows (lane k in slice k, row-major, row 0
//        oldest line); wv per-lane valid; row/col top-left coordinates of
//        lane 0 (col signed); err sticky line-length error.
module wnd_multi
  import wnd_pkg::*;
#(
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned PPC        = DEF_PPC,
  parameter int unsigned MAX_LINE_W = DEF_MAX_LINE_W
) (
  input  logic                         c,
  input  logic                         rst_n,
  input  logic [PPC*PIX_W-1:0]         p,
  input  logic                         pv,
  input  logic                         lv,
  input  logic                         fv,
  output logic [PPC*ROWS*COLS*PIX_W-1:0] w,
  output logic [PPC-1:0]               wv,
  output logic [ROW_W-1:0]             row,
  output logic [COL_W-1:0]             col,
  output logic                         err
);

  localparam int unsigned N_BEATS   = MAX_LINE_W / PPC;
  localparam int unsigned A_W       = clog2(N_BEATS);
  localparam int unsigned B_W       = clog2(N_BEATS + 1);
  localparam int unsigned WB_W      = COLS - 1 + PPC;
  localparam int unsigned BUS_W     = PPC * PIX_W;
  localparam int unsigned WIN_ROW_W = WB_W * PIX_W;
  localparam int unsigned OUT_W     = PPC * ROWS * COLS * PIX_W;

  logic [B_W-1:0]   r_b;
  logic [B_W-1:0]   r_b0;
  logic [ROW_W-1:0] r_l;
  logic             r_lv_d;

  logic             w_full;
  logic             w_acc;
  logic             w_line_end;
  logic [31:0]      w_n;
  logic             w_rows_ok;
  logic [PPC-1:0]   w_lane_v;

  logic             r_acc1;
  logic [BUS_W-1:0] r_p;
  logic [A_W-1:0]   r_waddr;
  logic [PPC-1:0]   r_wv1;
  wnd_coord_t       r_crd1;

  logic             r_acc2;
  logic [PPC-1:0]   r_wv2;
  wnd_coord_t       r_crd2;

  logic [WIN_ROW_W-1:0] r_win [ROWS];
  logic [BUS_W-1:0]     w_rd [ROWS-1];
  logic [BUS_W-1:0]     w_wdata [ROWS-1];
  logic [BUS_W-1:0]     w_in [ROWS];
  logic [OUT_W-1:0]     w_flat;

  // once the line is full, further beats are dropped until lv falls
  assign w_full     = (r_b == B_W'(N_BEATS));
  assign w_acc      = fv & lv & pv & ~w_full;
  assign w_line_end = r_lv_d & ~lv;

  // beat counter, line counter, reference line length and sticky error
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_lv_d <= 1'b0;
      r_b    <= '0;
      r_b0   <= '0;
      r_l    <= '0;
      err    <= 1'b0;
    end else begin
      r_lv_d <= lv;
      if (!fv) begin
        r_b  <= '0;
        r_b0 <= '0;
        r_l  <= '0;
        err  <= 1'b0;
      end else if (w_line_end) begin
        if (r_b != '0) begin
          if (r_l != '1) r_l <= r_l + ROW_W'(1);
          if (r_l == '0) r_b0 <= r_b;
          else if (r_b != r_b0) err <= 1'b1;
        end
        r_b <= '0;
      end else if (lv & pv) begin
        if (w_full) err <= 1'b1;
        else        r_b <= r_b + B_W'(1);
      end
    end
  end

  // lane validity and coordinates of the beat being accepted
  always_comb begin
    w_n       = (32'(r_b) + 32'd1) * 32'(PPC);
    w_rows_ok = (32'(r_l) >= 32'(ROWS - 1));
    w_lane_v  = '0;
    for (int k = 0; k < int'(PPC); k++) begin
      w_lane_v[k] = w_rows_ok && (w_n >= (32'(WB_W) - 32'(k)));
    end
  end

  // line buffer chain: buffer i takes the line held by buffer i+1, the last takes p
  for (genvar i = 0; i < int'(ROWS) - 1; i++) begin : g_buf
    if (i < int'(ROWS) - 2) begin : g_mid
      assign w_wdata[i] = w_rd[i+1];
    end else begin : g_last
      assign w_wdata[i] = r_p;
    end
    assign w_in[i] = w_rd[i];

    wnd_line_ram #(
      .DEPTH  (N_BEATS),
      .WIDTH  (BUS_W),
      .ADDR_W (A_W)
    ) u_ram (
      .i_clk   (c),
      .i_we    (r_acc1),
      .i_waddr (r_waddr),
      .i_wdata (w_wdata[i]),
      .i_re    (w_acc),
      .i_raddr (A_W'(r_b)),
      .o_rdata (w_rd[i])
    );
  end
  assign w_in[ROWS-1] = r_p;

  // pick each lane's COLS columns out of the shift register
  always_comb begin
    w_flat = '0;
    for (int k = 0; k < int'(PPC); k++) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int cc = 0; cc < int'(COLS); cc++) begin
          w_flat[((k*int'(ROWS) + r)*int'(COLS) + cc)*int'(PIX_W) +: PIX_W] =
            r_win[r][(k + cc)*int'(PIX_W) +: PIX_W];
        end
      end
    end
  end

  // accept -> window shift / RAM write -> output register
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_acc1  <= 1'b0;
      r_p     <= '0;
      r_waddr <= '0;
      r_wv1   <= '0;
      r_crd1  <= '0;
      r_acc2  <= 1'b0;
      r_wv2   <= '0;
      r_crd2  <= '0;
      for (int r = 0; r < int'(ROWS); r++) r_win[r] <= '0;
      w       <= '0;
      wv      <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      r_acc1 <= w_acc;
      r_wv1  <= w_acc ? w_lane_v : '0;
      if (w_acc) begin
        r_p        <= p;
        r_waddr    <= A_W'(r_b);
        r_crd1.row <= r_l - ROW_W'(ROWS - 1);
        r_crd1.col <= COL_W'(w_n - 32'(WB_W));
      end

      r_acc2 <= r_acc1;
      r_wv2  <= fv ? r_wv1 : '0;
      if (r_acc1) begin
        r_crd2 <= r_crd1;
        // oldest PPC columns fall off the left, new column enters at the right
        for (int r = 0; r < int'(ROWS); r++) begin
          r_win[r] <= {w_in[r], r_win[r][WIN_ROW_W-1:BUS_W]};
        end
      end

      wv <= fv ? r_wv2 : '0;
      if (r_acc2) begin
        w   <= w_flat;
        row <= r_crd2.row;
        col <= r_crd2.col;
      end
    end
  end

endmodule

// File: tb/tb_wnd_multi.sv
// Directed bench for wnd_multi: two PPC=2 3x3 instances (16- and 8-pixel
// line buffers) sharing one raster, plus a PPC=1 7x7 instance on a 640 ramp.
module tb_wnd_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [15:0]  p;
  logic         pv, lv, fv;
  logic [143:0] w_a, w_b;
  logic [1:0]   wv_a, wv_b;
  logic [9:0]   row_a, row_b, row_c;
  logic [11:0]  col_a, col_b, col_c;
  logic         err_a, err_b, err_c;
  logic [7:0]   pc;
  logic         pvc, lvc, fvc;
  logic [391:0] w_c;
  logic [0:0]   wv_c;

  wnd_multi #(.PIX_W(8), .COLS(3), .ROWS(3), .PPC(2), .MAX_LINE_W(16)) u_a (
    .c(clk), .rst_n(rst_n), .p(p), .pv(pv), .lv(lv), .fv(fv),
    .w(w_a), .wv(wv_a), .row(row_a), .col(col_a), .err(err_a));

  wnd_multi #(.PIX_W(8), .COLS(3), .ROWS(3), .PPC(2), .MAX_LINE_W(8)) u_b (
    .c(clk), .rst_n(rst_n), .p(p), .pv(pv), .lv(lv), .fv(fv),
    .w(w_b), .wv(wv_b), .row(row_b), .col(col_b), .err(err_b));

  wnd_multi #(.PIX_W(8), .COLS(7), .ROWS(7), .PPC(1), .MAX_LINE_W(1024)) u_c (
    .c(clk), .rst_n(rst_n), .p(pc), .pv(pvc), .lv(lvc), .fv(fvc),
    .w(w_c), .wv(wv_c), .row(row_c), .col(col_c), .err(err_c));

  int n_chk = 0;
  int n_fail = 0;
  int cnt_a, cnt_b, cnt_c;
  logic [11:0] q_col[$];
  logic [9:0]  q_row[$];

  typedef struct {
    int line; int beat; logic last; logic [1:0] wv; int row; int col;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cnt_a += $countones(wv_a);
    cnt_b += $countones(wv_b);
    cnt_c += $countones(wv_c);
    if (wv_a != 2'b00) begin
      q_col.push_back(col_a);
      q_row.push_back(row_a);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int cc);
    return 8'(r*16 + cc);
  endfunction

  function automatic logic [15:0] beat_pix(input int r, input int j);
    return {pix(r, 2*j+1), pix(r, 2*j)};
  endfunction

  function automatic logic [71:0] win_exp(input int r0, input int c0);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int cc = 0; cc < 3; cc++)
        v[(i*3 + cc)*8 +: 8] = pix(r0 + i, c0 + cc);
    return v;
  endfunction

  task automatic send_line(input int r, input int nb);
    fv = 1'b1; lv = 1'b1;
    for (int j = 0; j < nb; j++) begin
      p = beat_pix(r, j); pv = 1'b1;
      tick();
    end
    pv = 1'b0; lv = 1'b0;
    tick(); tick();
  endtask

  task automatic end_frame();
    pv = 1'b0; lv = 1'b0; fv = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_line, f_beat, seen;
    logic [11:0]  f_col;
    logic [9:0]   f_row;
    logic [391:0] f_win, exp_c;
    int line_cnt [7];

    vt[0]  = '{0,0,1'b0,2'b00,0,0};  vt[1]  = '{0,1,1'b0,2'b00,0,0};
    vt[2]  = '{0,2,1'b0,2'b00,0,0};  vt[3]  = '{0,3,1'b1,2'b00,0,0};
    vt[4]  = '{1,0,1'b0,2'b00,0,0};  vt[5]  = '{1,1,1'b0,2'b00,0,0};
    vt[6]  = '{1,2,1'b0,2'b00,0,0};  vt[7]  = '{1,3,1'b1,2'b00,0,0};
    vt[8]  = '{2,0,1'b0,2'b00,0,0};  vt[9]  = '{2,1,1'b0,2'b11,0,0};
    vt[10] = '{2,2,1'b0,2'b11,0,2};  vt[11] = '{2,3,1'b1,2'b11,0,4};
    vt[12] = '{3,0,1'b0,2'b00,0,0};  vt[13] = '{3,1,1'b0,2'b11,1,0};
    vt[14] = '{3,2,1'b0,2'b11,1,2};  vt[15] = '{3,3,1'b1,2'b11,1,4};

    rst_n = 1'b0; p = '0; pv = 0; lv = 0; fv = 0;
    pc = '0; pvc = 0; lvc = 0; fvc = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    #3;
    chk("rst_w", w_a, '0);
    chk("rst_wv", wv_a, '0);
    chk("rst_row", row_a, '0);
    chk("rst_col", col_a, '0);
    chk("rst_err", err_a, '0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ramp frame, one beat at a time with 3 idle cycles after each
    fv = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      lv = 1'b1; fv = 1'b1;
      p = beat_pix(vt[i].line, vt[i].beat); pv = 1'b1;
      tick();
      pv = 1'b0;
      tick();
      chk("gap_wv", wv_a, 2'b00);
      tick();
      chk($sformatf("tbl_wv_l%0d_b%0d", vt[i].line, vt[i].beat), wv_a, vt[i].wv);
      if (vt[i].wv != 2'b00) begin
        chk("tbl_row", row_a, 10'(vt[i].row));
        chk("tbl_col", col_a, 12'(vt[i].col));
        chk("tbl_win0", w_a[71:0], win_exp(vt[i].row, vt[i].col));
        chk("tbl_win1", w_a[143:72], win_exp(vt[i].row, vt[i].col + 1));
      end
      tick();
      if (vt[i].last) begin
        lv = 1'b0; tick(); tick();
      end
    end
    chk("ramp_err", err_a, 1'b0);
    end_frame();

    // back-to-back beats: line-edge mask and window count per line
    fv = 1'b1; tick();
    for (int r = 0; r < 4; r++) begin
      cnt_a = 0; q_col.delete(); q_row.delete();
      send_line(r, 4);
      chk($sformatf("strm_cnt_l%0d", r), 32'(cnt_a), (r >= 2) ? 32'd6 : 32'd0);
      if (r >= 2) begin
        chk("strm_qsize", 32'(q_col.size()), 32'd3);
        for (int i = 0; i < 3 && i < q_col.size(); i++) begin
          chk("strm_col", q_col[i], 12'(2*i));
          chk("strm_row", q_row[i], 10'(r - 2));
        end
      end
    end
    end_frame();

    // short second line raises err, fv low clears it
    fv = 1'b1; tick();
    send_line(0, 4);
    chk("len_err_before", err_a, 1'b0);
    send_line(1, 3);
    chk("len_err_set", err_a, 1'b1);
    fv = 1'b0; tick();
    chk("len_err_clr", err_a, 1'b0);
    end_frame();

    // 5-beat line into the 8-pixel buffer overflows
    fv = 1'b1; tick();
    send_line(0, 4);
    send_line(1, 4);
    cnt_a = 0; cnt_b = 0;
    lv = 1'b1;
    for (int j = 0; j < 5; j++) begin
      p = beat_pix(2, j); pv = 1'b1;
      tick();
      if (j == 3) chk("ovf_err_full", err_b, 1'b0);
      if (j == 4) begin
        chk("ovf_err_set", err_b, 1'b1);
        chk("ovf_a_noerr", err_a, 1'b0);
      end
    end
    pv = 1'b0; lv = 1'b0;
    tick(); tick();
    chk("ovf_cnt_b", 32'(cnt_b), 32'd6);
    chk("ovf_cnt_a", 32'(cnt_a), 32'd8);
    chk("ovf_a_lenerr", err_a, 1'b1);
    chk("ovf_b_col", col_b, 12'd4);
    chk("ovf_b_row", row_b, 10'd0);
    chk("ovf_b_win0", w_b[71:0], win_exp(0, 4));
    chk("ovf_b_win1", w_b[143:72], win_exp(0, 5));
    end_frame();

    // asynchronous reset in the middle of line 3
    fv = 1'b1; tick();
    send_line(0, 4); send_line(1, 4); send_line(2, 4);
    lv = 1'b1;
    for (int j = 0; j < 2; j++) begin
      p = beat_pix(3, j); pv = 1'b1; tick();
    end
    chk("pre_rst_col", col_a, 12'd4);
    p = beat_pix(3, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_w", w_a, '0);
    chk("arst_wv", wv_a, '0);
    chk("arst_row", row_a, '0);
    chk("arst_col", col_a, '0);
    chk("arst_err", err_a, '0);
    pv = 1'b0; lv = 1'b0; fv = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fv = 1'b1; tick();
    q_col.delete(); q_row.delete(); cnt_a = 0;
    send_line(0, 4); send_line(1, 4); send_line(2, 4);
    chk("post_rst_cnt", 32'(cnt_a), 32'd6);
    if (q_row.size() > 0) begin
      chk("post_rst_row", q_row[0], 10'd0);
      chk("post_rst_col", q_col[0], 12'd0);
    end else begin
      chk("post_rst_any", 32'(q_row.size()), 32'd1);
    end
    end_frame();

    // PPC=1, 7x7, 640-pixel ramp
    seen = 0; f_line = -1; f_beat = -1; f_col = '1; f_row = '1; f_win = '0;
    fvc = 1'b1; tick();
    for (int r = 0; r < 7; r++) begin
      cnt_c = 0;
      lvc = 1'b1;
      for (int j = 0; j < 640; j++) begin
        pc = pix(r, j); pvc = 1'b1;
        tick();
        if (seen == 0 && wv_c[0]) begin
          seen = 1; f_line = r; f_beat = j - 2;
          f_col = col_c; f_row = row_c; f_win = w_c;
        end
      end
      pvc = 1'b0; lvc = 1'b0;
      tick(); tick();
      line_cnt[r] = cnt_c;
    end
    exp_c = '0;
    for (int i = 0; i < 7; i++)
      for (int cc = 0; cc < 7; cc++)
        exp_c[(i*7 + cc)*8 +: 8] = pix(i, cc);
    chk("c_first_line", 32'(f_line), 32'd6);
    chk("c_first_beat", 32'(f_beat), 32'd6);
    chk("c_first_col", f_col, 12'd0);
    chk("c_first_row", f_row, 10'd0);
    chk("c_first_win", f_win, exp_c);
    chk("c_early_cnt", 32'(line_cnt[0] + line_cnt[1] + line_cnt[2] + line_cnt[3]
                          + line_cnt[4] + line_cnt[5]), 32'd0);
    chk("c_line6_cnt", 32'(line_cnt[6]), 32'd634);
    chk("c_err", err_c, 1'b0);
    fvc = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
